// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the device-side PS/2 sender.
// Holds the frame size, FSM state type, parity/frame helpers and scan codes.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE,
      HIGH,
      LOW,
      GAP,
      INHIBIT
   } ps2_state_e;

   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_B     = 8'h32;
   localparam logic [7:0] SC_C     = 8'h21;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

   // Wire order, LSB first: start, data[0..7], parity, stop.
   function automatic logic [PS2_FRAME_BITS-1:0] make_frame(
      input logic [7:0] b
   );
      return {1'b1, odd_parity(b), b, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_half_timer.sv
// ps2_half_timer: loadable down-counter that holds at zero.
// Ports: clk_i, reset_i (sync, active high), load_i/load_val_i (load),
//        en_i (count enable), cnt_o (current count), zero_o (count == 0).
module ps2_half_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_key_sender.sv
// ps2_key_sender: device-side PS/2 keyboard transmitter.
// Ports: clk, reset (sync, active high); in_data/in_valid/in_ready byte
//        handshake; host_inhibit (host pulls clock low); ps2clk/ps2data
//        toward host (idle high); busy (not idle); done (byte delivered).
module ps2_key_sender
   import ps2_pkg::*;
#(
   parameter int CLK_MHZ = 25,
   parameter int HALF_US = 40,
   parameter int GAP_US  = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       host_inhibit,
   output logic       ps2clk,
   output logic       ps2data,
   output logic       busy,
   output logic       done
);

   localparam int HALF_CYC = CLK_MHZ * HALF_US;
   localparam int GAP_CYC  = CLK_MHZ * GAP_US;
   localparam int MAX_CYC  = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
   localparam int CW       = $clog2(MAX_CYC + 1);

   // The timer reaches zero on the last cycle of an interval, so
   // an N-cycle interval is loaded with N-1.
   localparam logic [CW-1:0] HALF_LD  = CW'(HALF_CYC - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
   localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);

   ps2_state_e                state_q;
   logic [PS2_FRAME_BITS-1:0] shift_q;
   logic [7:0]                byte_q;
   logic [3:0]                bit_q;
   logic                      retry_q;
   logic                      clk_q;
   logic                      data_q;
   logic                      done_q;

   logic          accept;
   logic          abort;
   logic          last_bit;
   logic          done_d;
   logic          tmr_load;
   logic          tmr_zero;
   logic [CW-1:0] tmr_val;
   logic [CW-1:0] tmr_cnt;

   assign in_ready = (state_q == IDLE) && !host_inhibit && !reset;
   assign accept   = in_valid && in_ready;
   assign last_bit = (bit_q == LAST_BIT);

   // Inhibit during the stop bit is ignored: the host has
   // already sampled parity, so the byte counts as sent.
   assign abort = ((state_q == HIGH) || (state_q == LOW))
                  && host_inhibit && !last_bit;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = HALF_LD;
      unique case (state_q)
         IDLE: begin
            tmr_load = accept;
         end
         HIGH: begin
            tmr_load = tmr_zero && !abort;
         end
         LOW: begin
            tmr_load = tmr_zero && !abort;
            if (last_bit) begin
               tmr_val = GAP_LD;
            end
         end
         GAP: begin
            tmr_load = tmr_zero && retry_q;
         end
         INHIBIT: begin
            tmr_load = !host_inhibit;
            tmr_val  = GAP_LD;
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   // done is registered, so it is raised one edge ahead of the
   // final gap cycle; a one-cycle gap needs the LOW->GAP edge.
   always_comb begin
      done_d = 1'b0;
      if ((state_q == GAP) && !retry_q) begin
         done_d = (tmr_cnt == CW'(1));
      end
      if ((GAP_CYC == 1) && (state_q == LOW)
          && tmr_zero && last_bit && !abort) begin
         done_d = 1'b1;
      end
   end

   ps2_half_timer #(
      .W (CW)
   ) u_timer (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (busy),
      .cnt_o      (tmr_cnt),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '1;
         byte_q  <= '0;
         bit_q   <= '0;
         retry_q <= 1'b0;
         clk_q   <= 1'b1;
         data_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  byte_q  <= in_data;
                  shift_q <= make_frame(in_data);
                  bit_q   <= '0;
                  clk_q   <= 1'b1;
                  data_q  <= 1'b0;
                  state_q <= HIGH;
               end
            end
            HIGH: begin
               if (abort) begin
                  clk_q   <= 1'b1;
                  data_q  <= 1'b1;
                  retry_q <= 1'b1;
                  state_q <= INHIBIT;
               end else if (tmr_zero) begin
                  clk_q   <= 1'b0;
                  state_q <= LOW;
               end
            end
            LOW: begin
               if (abort) begin
                  clk_q   <= 1'b1;
                  data_q  <= 1'b1;
                  retry_q <= 1'b1;
                  state_q <= INHIBIT;
               end else if (tmr_zero) begin
                  clk_q <= 1'b1;
                  if (last_bit) begin
                     data_q  <= 1'b1;
                     state_q <= GAP;
                  end else begin
                     // Data only moves while the clock is high.
                     shift_q <= {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
                     data_q  <= shift_q[1];
                     bit_q   <= bit_q + 4'd1;
                     state_q <= HIGH;
                  end
               end
            end
            GAP: begin
               if (tmr_zero) begin
                  if (retry_q) begin
                     // Resend the held byte from the start bit.
                     shift_q <= make_frame(byte_q);
                     bit_q   <= '0;
                     retry_q <= 1'b0;
                     clk_q   <= 1'b1;
                     data_q  <= 1'b0;
                     state_q <= HIGH;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            INHIBIT: begin
               if (!host_inhibit) begin
                  state_q <= GAP;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ps2clk  = clk_q;
   assign ps2data = data_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_ps2_key_sender.sv
// tb_ps2_key_sender: directed and random checks of ps2_key_sender
// against a frame model and a loopback PS/2 receiver.
module tb_ps2_key_sender;
   import ps2_pkg::*;

   localparam int H = 4;
   localparam int G = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       host_inhibit = 1'b0;
   logic       ps2clk;
   logic       ps2data;
   logic       busy;
   logic       done;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   ps2_key_sender #(
      .CLK_MHZ (1),
      .HALF_US (H),
      .GAP_US  (G)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .host_inhibit (host_inhibit),
      .ps2clk       (ps2clk),
      .ps2data      (ps2data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Loopback receiver: samples data on ps2clk falls, like a host.
   int         fall_cyc[$];
   logic       fall_bit[$];
   logic [7:0] rx_q[$];
   logic       rxpar_q[$];
   int         done_cyc[$];
   int         idle_run_q[$];
   int         frame_err = 0;
   int         nb = 0;
   int         run = 0;
   logic       rbits[11];
   logic       prev_clk = 1'b1;
   logic       prev_data = 1'b1;

   always @(negedge clk) begin
      logic [7:0] b;
      int ones;
      if (reset || host_inhibit) begin
         nb = 0;
      end else if (prev_clk === 1'b1 && ps2clk === 1'b0) begin
         fall_cyc.push_back(cyc);
         fall_bit.push_back(ps2data);
         rbits[nb] = ps2data;
         nb++;
         if (nb == 11) begin
            ones = 0;
            for (int i = 0; i < 8; i++) begin
               b[i] = rbits[i+1];
               ones += int'(rbits[i+1]);
            end
            ones += int'(rbits[9]);
            if (rbits[0] !== 1'b0 || rbits[10] !== 1'b1 || ones % 2 != 1)
               frame_err++;
            rx_q.push_back(b);
            rxpar_q.push_back(rbits[9]);
            nb = 0;
         end
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (prev_clk && prev_data && ps2clk === 1'b1 && ps2data === 1'b0)
         idle_run_q.push_back(run);
      if (ps2clk === 1'b1 && ps2data === 1'b1) run++;
      else run = 0;
      prev_clk = ps2clk;
      prev_data = ps2data;
   end

   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         ones += int'(b[i]);
      end
      f[9] = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon;
      fall_cyc.delete();
      fall_bit.delete();
      rx_q.delete();
      rxpar_q.delete();
      done_cyc.delete();
      idle_run_q.delete();
   endtask

   task automatic send(input logic [7:0] b, output int t);
      int n = 0;
      while (in_ready !== 1'b1 && n < 400) begin
         tick;
         n++;
      end
      chk("send_ready", 32'(in_ready), 1);
      in_data = b;
      in_valid = 1'b1;
      tick;
      t = cyc;
      in_valid = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         tick;
         n++;
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, t1, t2, n;
      logic [10:0] ef;
      logic [7:0] b;
      logic [7:0] sent[$];
      logic brk, key_brk;
      logic [7:0] key;

      // Reset state
      tick;
      tick;
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_clk", 32'(ps2clk), 1);
      chk("rst_data", 32'(ps2data), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      reset = 1'b0;
      tick;
      chk("ready_after_rst", 32'(in_ready), 1);

      // Single ENTER byte: bit values and timing
      clear_mon();
      send(SC_ENTER, t0);
      chk("start_bit", 32'(ps2data), 0);
      chk("start_clk", 32'(ps2clk), 1);
      chk("busy_frame", 32'(busy), 1);
      chk("ready_frame", 32'(in_ready), 0);
      wait_idle(300);
      ef = exp_frame(SC_ENTER);
      chk("n_falls", fall_cyc.size(), 11);
      for (int i = 0; i < 11; i++) begin
         if (i < fall_cyc.size()) begin
            chk("fall_time", fall_cyc[i] - t0, H + 2 * H * i);
            chk("fall_bit", 32'(fall_bit[i]), 32'(ef[i]));
         end
      end
      chk("n_done", done_cyc.size(), 1);
      // t0 is already the first cycle after the transfer edge.
      if (done_cyc.size() > 0)
         chk("done_lat", done_cyc[0] - t0, 22 * H + G - 1);
      chk("idle_at", cyc - t0, 22 * H + G);
      chk("ready_back", 32'(in_ready), 1);
      chk("done_low", 32'(done), 0);
      if (rx_q.size() > 0) chk("rx_enter", 32'(rx_q[0]), 32'(SC_ENTER));

      // Back-to-back 1C, 00 with in_valid held
      clear_mon();
      in_data = 8'h1C;
      in_valid = 1'b1;
      tick;
      t1 = cyc;
      in_data = 8'h00;
      n = 0;
      while (in_ready !== 1'b1 && n < 300) begin
         tick;
         n++;
      end
      tick;
      t2 = cyc;
      in_valid = 1'b0;
      chk("b2b_spacing", t2 - t1, 22 * H + G + 1);
      wait_idle(300);
      chk("b2b_n", rx_q.size(), 2);
      chk("b2b_done", done_cyc.size(), 2);
      if (rx_q.size() == 2) begin
         chk("b2b_rx0", 32'(rx_q[0]), 32'h1C);
         chk("b2b_rx1", 32'(rx_q[1]), 32'h00);
         ef = exp_frame(8'h1C);
         chk("b2b_par0", 32'(rxpar_q[0]), 32'(ef[9]));
         ef = exp_frame(8'h00);
         chk("b2b_par1", 32'(rxpar_q[1]), 32'(ef[9]));
      end
      if (idle_run_q.size() > 0)
         chk("b2b_idle", idle_run_q[idle_run_q.size()-1], G + 1);

      // in_valid pulse while busy is ignored
      clear_mon();
      b = 8'($urandom);
      send(b, t0);
      repeat (30) tick;
      in_data = 8'hAA;
      in_valid = 1'b1;
      chk("aa_ready", 32'(in_ready), 0);
      tick;
      in_valid = 1'b0;
      wait_idle(300);
      repeat (120) tick;
      chk("aa_done", done_cyc.size(), 1);
      chk("aa_nrx", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("aa_rx", 32'(rx_q[0]), 32'(b));
      chk("aa_busy", 32'(busy), 0);

      // host_inhibit for 20 cycles during bit 4
      clear_mon();
      b = 8'($urandom);
      send(b, t0);
      while (cyc < t0 + 8 * H + 1) tick;
      host_inhibit = 1'b1;
      tick;
      chk("inh_clk", 32'(ps2clk), 1);
      chk("inh_data", 32'(ps2data), 1);
      chk("inh_busy", 32'(busy), 1);
      chk("inh_ready", 32'(in_ready), 0);
      repeat (19) tick;
      host_inhibit = 1'b0;
      t1 = cyc;
      while (cyc < t1 + G) tick;
      chk("gap_clk", 32'(ps2clk), 1);
      chk("gap_data", 32'(ps2data), 1);
      chk("gap_ready", 32'(in_ready), 0);
      tick;
      t2 = cyc;
      chk("resend_start", 32'(ps2data), 0);
      wait_idle(300);
      chk("inh_falls", fall_cyc.size(), 4 + 11);
      chk("inh_ndone", done_cyc.size(), 1);
      if (done_cyc.size() > 0)
         chk("inh_done_lat", done_cyc[0] - t2, 22 * H + G - 1);
      chk("inh_nrx", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("inh_rx", 32'(rx_q[0]), 32'(b));

      // Reset during bit 6
      clear_mon();
      b = 8'($urandom);
      send(b, t0);
      while (cyc < t0 + 12 * H + 1) tick;
      reset = 1'b1;
      tick;
      chk("mrst_clk", 32'(ps2clk), 1);
      chk("mrst_data", 32'(ps2data), 1);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ready", 32'(in_ready), 0);
      reset = 1'b0;
      tick;
      chk("mrst_ready_after", 32'(in_ready), 1);
      repeat (150) tick;
      chk("mrst_done", done_cyc.size(), 0);
      chk("mrst_rx", rx_q.size(), 0);

      // Break code sequence decoded by the host model
      clear_mon();
      send(SC_BREAK, t0);
      send(SC_B, t0);
      wait_idle(300);
      brk = 1'b0;
      key_brk = 1'b0;
      key = 8'h00;
      foreach (rx_q[i]) begin
         if (rx_q[i] == SC_BREAK) begin
            brk = 1'b1;
         end else begin
            key = rx_q[i];
            key_brk = brk;
            brk = 1'b0;
         end
      end
      chk("brk_nrx", rx_q.size(), 2);
      chk("brk_key", 32'(key), 32'(SC_B));
      chk("brk_flag", 32'(key_brk), 1);
      chk("brk_perr", frame_err, 0);

      // Random bytes with random idle spacing
      clear_mon();
      sent.delete();
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom);
         repeat ($urandom_range(0, 20)) tick;
         send(b, t0);
         sent.push_back(b);
      end
      wait_idle(300);
      chk("rnd_nrx", rx_q.size(), sent.size());
      chk("rnd_ndone", done_cyc.size(), sent.size());
      for (int k = 0; k < 6; k++) begin
         if (k < rx_q.size()) begin
            ef = exp_frame(sent[k]);
            chk("rnd_rx", 32'(rx_q[k]), 32'(sent[k]));
            chk("rnd_par", 32'(rxpar_q[k]), 32'(ef[9]));
         end
      end
      chk("rnd_perr", frame_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
